// File: rtl/slice_adder_pkg.sv
// Shared types and elaboration helpers for the slice-serial adder.
package slice_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int slice);
    return (slice > 0) ? width / slice : 1;
  endfunction

  // A one-slice adder still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational SLICE-bit full adder; the sequential adder reuses one instance.
module fa_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  localparam int SUM_W = SLICE + 1;

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + SUM_W'(ci);
  end

endmodule

// File: rtl/slice_adder_seq.sv
// Multi-cycle WIDTH-bit adder rippling one SLICE-bit slice per clock.
// Optional signed-overflow output enabled by defining SLICE_ADDER_OVF_EN.
module slice_adder_seq
  import slice_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             co
`ifdef SLICE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDX_W  = idx_width(NSLICE);

  if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("slice_adder_seq: WIDTH must be a positive multiple of SLICE");
  end

  state_t             state, state_nxt;
  logic               accept, last;
  logic [WIDTH-1:0]   a_r, b_r;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [SLICE-1:0]   a_sl, b_sl, s_sl;
  logic               c_sl;

  // Operand slice selected by the running index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx == IDX_W'(k)) begin
        a_sl = a_r[k*SLICE +: SLICE];
        b_sl = b_r[k*SLICE +: SLICE];
      end
    end
  end

  fa_slice #(.SLICE(SLICE)) u_fa (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .s  (s_sl),
    .co (c_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (idx == IDX_W'(NSLICE - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flops fed from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      y     <= '0;
      co    <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        carry <= ci;
        idx   <= '0;
      end else if (state == RUN) begin
        for (int k = 0; k < NSLICE; k++) begin
          if (idx == IDX_W'(k)) y[k*SLICE +: SLICE] <= s_sl;
        end
        carry <= c_sl;
        if (last) co  <= c_sl;
        else      idx <= idx + IDX_W'(1);
      end
    end
  end

`ifdef SLICE_ADDER_OVF_EN
  // Like-signed operands whose sum flips sign overflowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_sl[SLICE-1] != a_r[WIDTH-1]);
    end
  end
`endif

endmodule
